// File: rtl/trigger_trans_detection_pkg.sv
// ---------------------------------------------------------------------------
// trigger_trans_detection_pkg
//   Shared constants for the trigger / transition qualifier of the logic
//   capture path.
//     DEFAULT_SAMPLE_WIDTH : default number of logic channels per sample
//     EDGE_RISING          : edgeType value selecting a 0->1 edge
//     EDGE_FALLING         : edgeType value selecting a 1->0 edge
// ---------------------------------------------------------------------------
package trigger_trans_detection_pkg;

    localparam int   DEFAULT_SAMPLE_WIDTH = 8;

    localparam logic EDGE_RISING  = 1'b1;
    localparam logic EDGE_FALLING = 1'b0;

endpackage : trigger_trans_detection_pkg

// File: rtl/trigger_trans_detection_pattern_match.sv
// ---------------------------------------------------------------------------
// pattern_match
//   Masked level compare of one sample against a desired pattern.
//   A channel takes part only when it is active and not marked don't-care.
//   With no participating channel the match is vacuously true.
//   Ports:
//     sample       in  current sample levels
//     pattern      in  required level per channel
//     active       in  1 = channel enabled
//     dontCare     in  1 = channel ignored by the compare
//     match        out 1 = every participating channel equals the pattern
// ---------------------------------------------------------------------------
module pattern_match
    import trigger_trans_detection_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH
) (
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [SAMPLE_WIDTH-1:0] pattern,
    input  logic [SAMPLE_WIDTH-1:0] active,
    input  logic [SAMPLE_WIDTH-1:0] dontCare,
    output logic                    match
);

    logic [SAMPLE_WIDTH-1:0] checkedChannels;
    logic [SAMPLE_WIDTH-1:0] mismatchBits;

    assign checkedChannels = active & ~dontCare;
    assign mismatchBits    = (sample ^ pattern) & checkedChannels;
    assign match           = (mismatchBits == '0);

endmodule : pattern_match

// File: rtl/trigger_trans_detection.sv
// ---------------------------------------------------------------------------
// trigger_trans_detection
//   Trigger and transition qualifier for the logic-capture path.
//   Compares each (latest, previous) sample pair against the configured edge
//   and pattern trigger conditions and against the active-channel mask.
//   Ports:
//     clk, rst               clock and synchronous active-high reset
//     latestSample           current sample
//     previousSample         sample from the prior capture cycle
//     activeChannels         1 = channel enabled
//     edgeChannel            channel index watched by the edge trigger
//     edgeType               1 = rising, 0 = falling
//     edgeTriggerEnabled     edge condition participates in the trigger
//     patternTriggerEnabled  pattern condition participates in the trigger
//     desiredPattern         required level per channel
//     dontCareChannels       1 = channel ignored in the pattern match
//     triggered              combined trigger (combinational)
//     transition             any active channel changed (combinational)
//     triggeredReg           triggered, registered on clk
//     transitionReg          transition, registered on clk
// ---------------------------------------------------------------------------
module trigger_trans_detection
    import trigger_trans_detection_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] latestSample,
    input  logic [SAMPLE_WIDTH-1:0] previousSample,
    input  logic [SAMPLE_WIDTH-1:0] activeChannels,
    input  logic signed [31:0]      edgeChannel,
    input  logic                    edgeType,
    input  logic                    edgeTriggerEnabled,
    input  logic                    patternTriggerEnabled,
    input  logic [SAMPLE_WIDTH-1:0] desiredPattern,
    input  logic [SAMPLE_WIDTH-1:0] dontCareChannels,
    output logic                    triggered,
    output logic                    transition,
    output logic                    triggeredReg,
    output logic                    transitionReg
);

    logic edgeTrigger;
    logic patternTrigger;
    logic edgeLatest;
    logic edgePrevious;
    logic edgeInRange;

    // Channel selection by compare rather than by indexing keeps an
    // out-of-range (including negative) edgeChannel from aliasing onto a
    // real channel: no compare hits and the edge trigger stays low.
    always_comb begin
        edgeLatest   = 1'b0;
        edgePrevious = 1'b0;
        edgeInRange  = 1'b0;
        for (int k = 0; k < SAMPLE_WIDTH; k++) begin
            if (edgeChannel == k) begin
                edgeLatest   = latestSample[k];
                edgePrevious = previousSample[k];
                edgeInRange  = 1'b1;
            end
        end
    end

    always_comb begin
        if (edgeType == EDGE_RISING) begin
            edgeTrigger = edgeInRange & ~edgePrevious & edgeLatest;
        end else begin
            edgeTrigger = edgeInRange & edgePrevious & ~edgeLatest;
        end
    end

    pattern_match #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH)
    ) uPatternMatch (
        .sample  (latestSample),
        .pattern (desiredPattern),
        .active  (activeChannels),
        .dontCare(dontCareChannels),
        .match   (patternTrigger)
    );

    // A disabled condition counts as satisfied, so both enables low gives
    // free-running capture.
    assign triggered  = (~edgeTriggerEnabled    | edgeTrigger) &
                        (~patternTriggerEnabled | patternTrigger);

    assign transition = |(activeChannels & (latestSample ^ previousSample));

    // Stage p0 -> p1: registered copies for pipelined consumers
    always_ff @(posedge clk) begin
        if (rst) begin
            triggeredReg  <= 1'b0;
            transitionReg <= 1'b0;
        end else begin
            triggeredReg  <= triggered;
            transitionReg <= transition;
        end
    end

endmodule : trigger_trans_detection

// File: tb/tb_trigger_trans_detection.sv
// ---------------------------------------------------------------------------
// tb_trigger_trans_detection
//   Scoreboard bench: the driver applies a vector on the falling edge and
//   queues the expected response from a channel-by-channel reference model;
//   the monitor pops one entry per rising edge and compares all outputs.
// ---------------------------------------------------------------------------
module tb_trigger_trans_detection;
    import trigger_trans_detection_pkg::*;

    localparam int W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [W-1:0]       latest, prev, active, desired, dontCare;
    logic signed [31:0] ch;
    logic               eType, eEn, pEn;
    logic               triggered, transition, triggeredReg, transitionReg;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic trig;
        logic trans;
        logic edg;
        logic pat;
        logic regT;
        logic regX;
    } exp_t;

    exp_t expQ[$];

    trigger_trans_detection #(.SAMPLE_WIDTH(W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .latestSample         (latest),
        .previousSample       (prev),
        .activeChannels       (active),
        .edgeChannel          (ch),
        .edgeType             (eType),
        .edgeTriggerEnabled   (eEn),
        .patternTriggerEnabled(pEn),
        .desiredPattern       (desired),
        .dontCareChannels     (dontCare),
        .triggered            (triggered),
        .transition           (transition),
        .triggeredReg         (triggeredReg),
        .transitionReg        (transitionReg)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic refEdge(input logic [W-1:0] l, input logic [W-1:0] p,
                                     input int c, input logic t);
        int lv, pv;
        if (c < 0 || c >= W) return 1'b0;
        lv = (int'(l) >> c) % 2;
        pv = (int'(p) >> c) % 2;
        if (t) return (pv == 0 && lv == 1);
        return (pv == 1 && lv == 0);
    endfunction

    function automatic logic refPattern(input logic [W-1:0] l, input logic [W-1:0] d,
                                        input logic [W-1:0] a, input logic [W-1:0] dc);
        for (int k = 0; k < W; k++) begin
            if (a[k] == 1'b1 && dc[k] == 1'b0 && l[k] != d[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic refTrans(input logic [W-1:0] l, input logic [W-1:0] p,
                                      input logic [W-1:0] a);
        int changed = 0;
        for (int k = 0; k < W; k++) begin
            if (a[k] == 1'b1 && l[k] != p[k]) changed++;
        end
        return changed > 0;
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic r, input logic [W-1:0] l, input logic [W-1:0] p,
                        input logic [W-1:0] a, input int c, input logic t,
                        input logic ee, input logic pe, input logic [W-1:0] d,
                        input logic [W-1:0] dc);
        exp_t e;
        @(negedge clk);
        rst = r; latest = l; prev = p; active = a; ch = c; eType = t;
        eEn = ee; pEn = pe; desired = d; dontCare = dc;
        e.edg   = refEdge(l, p, c, t);
        e.pat   = refPattern(l, d, a, dc);
        e.trig  = (ee ? e.edg : 1'b1) && (pe ? e.pat : 1'b1);
        e.trans = refTrans(l, p, a);
        e.regT  = r ? 1'b0 : e.trig;
        e.regX  = r ? 1'b0 : e.trans;
        expQ.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string name, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("triggered",      triggered,          e.trig);
                check("transition",     transition,         e.trans);
                check("edgeTrigger",    dut.edgeTrigger,    e.edg);
                check("patternTrigger", dut.patternTrigger, e.pat);
                check("triggeredReg",   triggeredReg,       e.regT);
                check("transitionReg",  transitionReg,      e.regX);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int chans[11];
        rst = 1'b1; latest = '0; prev = '0; active = '0; ch = 0; eType = 1'b0;
        eEn = 1'b0; pEn = 1'b0; desired = '0; dontCare = '0;

        // Init: everything zero, reset held
        send(1, 8'h00, 8'h00, 8'h00, 0, EDGE_FALLING, 0, 0, 8'h00, 8'h00);
        send(1, 8'h00, 8'h00, 8'h00, 0, EDGE_FALLING, 0, 0, 8'h00, 8'h00);
        send(0, 8'h00, 8'h00, 8'h00, 0, EDGE_FALLING, 0, 0, 8'h00, 8'h00);

        // Edge sweep, including out-of-range channel indices
        chans = '{-5, -1, 0, 1, 2, 3, 4, 5, 6, 7, 8};
        for (int ci = 0; ci < 11; ci++) begin
            for (int j = 0; j < W; j++) begin
                logic [W-1:0] one;
                one = 8'(1 << j);
                send(0, one, 8'h00, 8'h00, chans[ci], EDGE_RISING,  1, 0, 8'h00, 8'h00);
                send(0, one, 8'h00, 8'h00, chans[ci], EDGE_FALLING, 1, 0, 8'h00, 8'h00);
                send(0, 8'h00, one, 8'h00, chans[ci], EDGE_FALLING, 1, 0, 8'h00, 8'h00);
                send(0, 8'h00, one, 8'h00, chans[ci], EDGE_RISING,  1, 0, 8'h00, 8'h00);
            end
        end
        send(0, 8'hFF, 8'h00, 8'h00, 32, EDGE_RISING, 1, 0, 8'h00, 8'h00);

        // Pattern only
        send(0, 8'h0C, 8'h00, 8'hFF, 0, EDGE_RISING, 0, 1, 8'h04, 8'h00);
        send(0, 8'h0C, 8'h00, 8'hFF, 0, EDGE_RISING, 0, 1, 8'h04, 8'h08);
        send(0, 8'h0C, 8'h00, 8'h00, 0, EDGE_RISING, 0, 1, 8'h04, 8'h00);

        // Combo: both conditions enabled on channel 0, rising
        send(0, 8'h03, 8'h02, 8'hFF, 0, EDGE_RISING, 1, 1, 8'h00, 8'h00);
        send(0, 8'h01, 8'h00, 8'hFF, 0, EDGE_RISING, 1, 1, 8'h01, 8'h00);
        send(0, 8'h01, 8'h01, 8'hFF, 0, EDGE_RISING, 1, 1, 8'h01, 8'h00);
        send(0, 8'h01, 8'h01, 8'hFF, 0, EDGE_RISING, 1, 1, 8'h00, 8'h00);

        // Reset mid-operation with a nonzero trigger/transition present
        send(1, 8'h01, 8'h00, 8'hFF, 0, EDGE_RISING, 0, 0, 8'h00, 8'h00);
        send(0, 8'h01, 8'h00, 8'hFF, 0, EDGE_RISING, 0, 0, 8'h00, 8'h00);

        // Static samples on all active channels: never a transition
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] s;
            s = 8'($urandom);
            send(0, s, s, 8'hFF, int'($urandom_range(0, 11)) - 2, 1'($urandom),
                 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        end

        // Fully random vectors with occasional reset
        for (int i = 0; i < 30000; i++) begin
            send(($urandom_range(0, 49) == 0), 8'($urandom), 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 11)) - 2, 1'($urandom), 1'($urandom),
                 1'($urandom), 8'($urandom), 8'($urandom));
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (expQ.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_trigger_trans_detection
